ds_dac_ctrl: RTL

Sample scheduler and soft-mute controller for the delta-sigma DAC. Paces 16-bit unsigned (offset-binary) samples from an upstream valid/ready source into the DAC `din` input at a fixed sample rate derived from `clk50m`. Ramps a digital gain on enable and disable, so the DAC output fades to and from mid-scale without clicks. Flags underruns when no sample is ready at a sample instant.

---
 rtl/ds_dac_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/ds_dac_ctrl.sv
// Sample scheduler and soft-mute controller for the delta-sigma DAC.
// Paces samples at clk50m/DIV and ramps a digital gain so the output fades to and from mid-scale.
module ds_dac_ctrl #(
    parameter int          DIV  = 1042,
    parameter int          STEP = 64,
    parameter logic [15:0] MID  = 16'h8000
) (
    input  logic        clk50m,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [15:0] dac_din,
    output logic        tick,
    output logic [1:0]  state,
    output logic        underrun,
    input  logic        clr_underrun
);

    localparam int          CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [16:0] G_FULL   = 17'h10000;
    localparam logic [16:0] STEP_G   = 17'(STEP);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_RAMP_UP   = 2'd1;
    localparam logic [1:0] ST_PLAY      = 2'd2;
    localparam logic [1:0] ST_RAMP_DOWN = 2'd3;

    logic [1:0]         state_r;
    logic [1:0]         state_nx_s;
    logic [CW-1:0]      cnt_r;
    logic [16:0]        g_r;
    logic [15:0]        cur_r;
    logic [15:0]        hold_r;
    logic               hold_v_r;
    logic               underrun_r;
    logic [15:0]        dac_din_r;

    logic               tick_s;
    logic               s_ready_s;
    logic               xfer_s;
    logic               going_idle_s;
    logic [17:0]        g_sum_s;
    logic [16:0]        g_up_s;
    logic [16:0]        g_dn_s;
    logic signed [16:0] d_s;
    logic signed [34:0] p_s;
    logic [15:0]        dac_nx_s;

    // Saturating gain candidates for the next tick in either ramp direction.
    always_comb begin
        g_sum_s = {1'b0, g_r} + {1'b0, STEP_G};
        if (g_sum_s >= {1'b0, G_FULL}) begin
            g_up_s = G_FULL;
        end else begin
            g_up_s = g_sum_s[16:0];
        end
        if (g_r > STEP_G) begin
            g_dn_s = g_r - STEP_G;
        end else begin
            g_dn_s = 17'd0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk50m or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state: enable changes act at once, gain end-points only on a tick.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enable) state_nx_s = ST_RAMP_UP;
                else        state_nx_s = ST_IDLE;
            end
            ST_RAMP_UP: begin
                if (!enable)                           state_nx_s = ST_RAMP_DOWN;
                else if (tick_s && (g_up_s == G_FULL)) state_nx_s = ST_PLAY;
                else                                   state_nx_s = ST_RAMP_UP;
            end
            ST_PLAY: begin
                if (!enable) state_nx_s = ST_RAMP_DOWN;
                else         state_nx_s = ST_PLAY;
            end
            ST_RAMP_DOWN: begin
                if (enable)                             state_nx_s = ST_RAMP_UP;
                else if (tick_s && (g_dn_s == 17'd0))   state_nx_s = ST_IDLE;
                else                                    state_nx_s = ST_RAMP_DOWN;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // FSM outputs derived from registered state.
    always_comb begin
        if (state_r != ST_IDLE) begin
            tick_s    = (cnt_r == CNT_LAST);
            s_ready_s = !hold_v_r;
        end else begin
            tick_s    = 1'b0;
            s_ready_s = 1'b0;
        end
        xfer_s       = s_valid && s_ready_s;
        going_idle_s = (state_r == ST_RAMP_DOWN) && (state_nx_s == ST_IDLE);
    end

    // Sample-period counter and gain ramp.
    always_ff @(posedge clk50m or posedge rst) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
            g_r   <= 17'd0;
        end else begin
            if ((state_r == ST_IDLE) || tick_s) begin
                cnt_r <= {CW{1'b0}};
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
            case (state_r)
                ST_IDLE:      g_r <= 17'd0;
                ST_RAMP_UP:   g_r <= tick_s ? g_up_s : g_r;
                ST_PLAY:      g_r <= G_FULL;
                ST_RAMP_DOWN: g_r <= tick_s ? g_dn_s : g_r;
                default:      g_r <= 17'd0;
            endcase
        end
    end

    // One-entry input buffer, current sample and sticky underrun flag.
    always_ff @(posedge clk50m or posedge rst) begin
        if (rst) begin
            hold_r     <= 16'h0000;
            hold_v_r   <= 1'b0;
            cur_r      <= MID;
            underrun_r <= 1'b0;
        end else begin
            if (xfer_s) begin
                hold_r <= s_data;
            end else begin
                hold_r <= hold_r;
            end
            if (going_idle_s) begin
                hold_v_r <= 1'b0;
            end else if (xfer_s) begin
                hold_v_r <= 1'b1;
            end else if (tick_s && hold_v_r) begin
                hold_v_r <= 1'b0;
            end else begin
                hold_v_r <= hold_v_r;
            end
            if (going_idle_s) begin
                cur_r <= MID;
            end else if (tick_s && hold_v_r) begin
                cur_r <= hold_r;
            end else begin
                cur_r <= cur_r;
            end
            // A new underrun beats a coincident clear.
            if (tick_s && !hold_v_r) begin
                underrun_r <= 1'b1;
            end else if (clr_underrun) begin
                underrun_r <= 1'b0;
            end else begin
                underrun_r <= underrun_r;
            end
        end
    end

    // Scale the sample around mid-scale; floor shift keeps the result inside 0..65535.
    always_comb begin
        d_s      = $signed({1'b0, cur_r}) - 17'sh08000;
        p_s      = 35'(d_s) * 35'($signed({1'b0, g_r}));
        dac_nx_s = 16'(p_s >>> 16) + 16'h8000;
    end

    // Output register to the DAC.
    always_ff @(posedge clk50m or posedge rst) begin
        if (rst) begin
            dac_din_r <= MID;
        end else begin
            dac_din_r <= dac_nx_s;
        end
    end

    assign s_ready  = s_ready_s;
    assign tick     = tick_s;
    assign state    = state_r;
    assign underrun = underrun_r;
    assign dac_din  = dac_din_r;

endmodule
